// File: rtl/asmd_shift_add_multiplier.sv
// rtl/asmd_shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier (ASMD)
// One partial product per cycle; product and ready are registered and change only at completion.
module asmd_shift_add_multiplier #(
  parameter int word_length = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [word_length-1:0]     word0,
  input  logic [word_length-1:0]     word1,
  input  logic                       start,
  output logic [2*word_length-1:0]   product,
  output logic                       ready
);

  localparam int PW = 2 * word_length;
  localparam int CW = $clog2(word_length + 1);

  typedef enum logic [1:0] {
    IDLE_RST,
    IDLE,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [word_length-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   product_q, product_d;
  logic            ready_q, ready_d;
  logic [PW-1:0]   acc_next;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    ready_d   = ready_q;
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

    case (state_q)
      IDLE_RST: begin
        // start is deliberately not looked at here; it is honoured one cycle later in IDLE
        ready_d = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        if (start) begin
          mcand_d  = {{word_length{1'b0}}, word0};
          mplier_d = word1;
          acc_d    = '0;
          count_d  = CW'(word_length);
          ready_d  = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        // product is only written here, so it stays stable for the whole run
        if (count_q == CW'(1)) begin
          product_d = acc_next;
          ready_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE_RST;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  assign product = product_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_asmd_shift_add_multiplier.sv
// tb/tb_asmd_shift_add_multiplier.sv - self-checking bench for asmd_shift_add_multiplier
// Directed vector table plus hand-written sequences for back-to-back, stability and abort cases.
module tb_asmd_shift_add_multiplier;

  logic       clk;
  logic       reset;
  logic [3:0] word0;
  logic [3:0] word1;
  logic       start;
  logic [7:0] product;
  logic       ready;

  int total;
  int bad;
  logic [7:0] prev;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[8];

  asmd_shift_add_multiplier #(.word_length(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .word0   (word0),
    .word1   (word1),
    .start   (start),
    .product (product),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts an operation from IDLE and waits for completion, checking latency and product hold.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                        input string nm);
    int n;
    word0 = a;
    word1 = b;
    start = 1'b1;
    tick();
    chk({nm, " accept ready"}, 32'(ready), 32'd0);
    start = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      chk({nm, " hold product"}, 32'(product), 32'(prev));
      tick();
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd4);
    chk({nm, " product"}, 32'(product), 32'(exp));
    prev = exp;
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    int gap;

    total = 0;
    bad   = 0;
    prev  = 8'd0;
    reset = 1'b0;
    start = 1'b0;
    word0 = 4'd0;
    word1 = 4'd0;

    vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'd225};
    vecs[1] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
    vecs[2] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};
    vecs[3] = '{a: 4'd1,  b: 4'd15, p: 8'd15};
    vecs[4] = '{a: 4'd8,  b: 4'd2,  p: 8'd16};
    vecs[5] = '{a: 4'd7,  b: 4'd9,  p: 8'd63};
    vecs[6] = '{a: 4'd10, b: 4'd13, p: 8'd130};
    vecs[7] = '{a: 4'd15, b: 4'd1,  p: 8'd15};

    // reset held with start low
    for (int i = 0; i < 10; i++) tick();
    chk("reset product", 32'(product), 32'd0);
    chk("reset ready", 32'(ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("ready after release", 32'(ready), 32'd1);
    tick();
    chk("idle ready holds", 32'(ready), 32'd1);

    // basic 5*3 with start held high for back-to-back operations
    word0 = 4'd5;
    word1 = 4'd3;
    start = 1'b1;
    for (int op = 0; op < 2; op++) begin
      tick();
      chk("b2b accept ready", 32'(ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
        chk("b2b hold product", 32'(product), 32'(prev));
        tick();
        chk("b2b busy ready", 32'(ready), 32'd0);
      end
      tick();
      chk("b2b done ready", 32'(ready), 32'd1);
      chk("b2b product", 32'(product), 32'd15);
      prev = 8'd15;
    end
    start = 1'b0;
    tick();
    chk("b2b stays idle", 32'(ready), 32'd1);

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // operand and start changes during RUN are ignored
    word0 = 4'd6;
    word1 = 4'd7;
    start = 1'b1;
    tick();
    chk("stab accept", 32'(ready), 32'd0);
    start = 1'b0;
    word0 = 4'd15;
    word1 = 4'd15;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stab busy ready", 32'(ready), 32'd0);
    chk("stab hold product", 32'(product), 32'(prev));
    tick();
    chk("stab done ready", 32'(ready), 32'd1);
    chk("stab product", 32'(product), 32'd42);
    tick();
    chk("stab no restart", 32'(ready), 32'd1);
    prev = 8'd42;

    // reset two cycles into a run aborts it
    word0 = 4'd12;
    word1 = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("abort product", 32'(product), 32'd0);
    chk("abort ready", 32'(ready), 32'd0);
    prev  = 8'd0;
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk("post-abort idle_rst ready", 32'(ready), 32'd1);
    tick();
    chk("post-abort accept", 32'(ready), 32'd0);
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("post-abort busy", 32'(ready), 32'd0);
    tick();
    chk("post-abort ready", 32'(ready), 32'd1);
    chk("post-abort product", 32'(product), 32'd132);
    prev = 8'd132;

    // random operands with random idle gaps
    for (int i = 0; i < 200; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      run_op(ra, rb, 8'(ra) * 8'(rb), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asmd_shift_add_multiplier.md
Name: asmd_shift_add_multiplier

Overview:
Sequential unsigned multiplier built as an ASMD (algorithmic state machine with datapath) using shift-and-add. It takes two word_length-bit operands on a start request and produces a 2*word_length-bit product after a fixed number of cycles, signalled by ready. It is a standalone arithmetic block. The RTL and any synthesized gate-level version must be cycle-for-cycle equivalent on product and ready.

Parameters:
word_length, 4, width of each operand; product width is 2*word_length.

Ports:
clk  input  1  rising-edge clock; sole clock domain
reset  input  1  synchronous, active-low reset (reset==0 resets on rising clk edge)
word0  input  word_length  multiplicand, unsigned; sampled only when a start is accepted
word1  input  word_length  multiplier, unsigned; sampled only when a start is accepted
start  input  1  level-sensitive request; accepted when high in IDLE
product  output  2*word_length  registered result; holds last completed product
ready  output  1  registered; high when idle with a valid/idle result, low while busy

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at clk edge): state<=IDLE_RST, product<=0, ready<=0, internal accumulator/shift registers/counter<=0. Overrides everything, including mid-operation (operation aborted, no partial result exposed).
- States: IDLE_RST (first cycle after reset release), IDLE, RUN.
- IDLE_RST: ready<=1, go to IDLE. If start is high in this cycle, it is ignored; it is accepted in IDLE on the next edge.
- IDLE (ready==1): if start==1 at clk edge:
  - load mcand<=zero-extended word0 (2W bits), mplier<=word1, acc<=0, count<=word_length;
  - ready<=0; go to RUN.
  - Otherwise hold; product unchanged.
- RUN, each edge:
  - if mplier[0], acc_next=acc+mcand, else acc_next=acc;
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count-1.
  - On the edge where count==1 (last iteration): product<=acc_next, ready<=1, go to IDLE.
- Latency: start sampled high at edge k, then ready==1 and the final product are visible after edge k+word_length. RUN lasts exactly word_length cycles, with no early termination.
- Arithmetic: unsigned; the result always fits in 2*word_length bits (max (2^W-1)^2), so there is no overflow or wrap.
- product updates only at completion (and is cleared at reset), never while RUN is in progress, so it stays stable while ready==0.
- start during RUN: ignored. word0/word1 changes during RUN: ignored.
- start held high continuously: back-to-back operations. ready is high for exactly one cycle (IDLE), then a new operation loads. product holds the previous result until the new completion.
- start must not be X after reset release. If unknown, it is treated as 0 in the bench.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset=0 for 10 cycles with start=0 -> product==0, ready==0. Release -> ready==1 one cycle later.
- Basic: word0=5, word1=3, start=1 -> ready falls next edge, rises exactly 4 cycles after acceptance, product==15 (0x0F). Keep start high: subsequent results stay 15, and product never glitches while ready==0.
- Boundaries: 15*15 -> 225 (0xE1); 0*9 -> 0; 9*0 -> 0; 1*15 -> 15; 8*2 -> 16. Each completes in 4 cycles.
- Input stability: start with 6*7, then change word0/word1 to 15/15 and pulse start during RUN -> result 42, with no restart until back in IDLE.
- Reset mid-operation: start 12*11, assert reset=0 after 2 RUN cycles -> next edge product==0, ready==0. After release and a new start 12*11 -> 132.
- Random: 200 random operand pairs with random start gaps, compared to a reference multiply on each ready rise. RTL and gate-level outputs are compared every cycle, with zero mismatches allowed.
